serial_add_ctrl: RTL and testbench

- Bit-serial add/subtract controller that time-shares a single one-bit full-adder cell across all bits of a WIDTH-bit operand pair.
- The cell is built from two of the team's half-adder cells; this block sequences it LSB-first, one bit per clock, and holds the carry between bits.
- It sits in the matrix-multiplication datapath as the low-area accumulator adder.
- Upstream requesters hand it operands over a valid/ready handshake; results leave over a second valid/ready handshake.

---
 rtl/serial_add_pkg.sv | 17 +
 rtl/bit_full_adder.sv | 32 +++
 rtl/serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_serial_add_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial add/subtract controller:
//   - DEF_WIDTH : default operand/result width
//   - state_e   : controller state encoding (IDLE/RUN/DONE)
// -----------------------------------------------------------------------------
package serial_add_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bit_full_adder.sv
// -----------------------------------------------------------------------------
// bit_full_adder
// One-bit full adder made of two half-adder stages and an OR gate.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit
//   cout  : carry out
// -----------------------------------------------------------------------------
module bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    // first half-adder: a + b
    assign s1 = a ^ b;
    assign c1 = a & b;

    // second half-adder: partial sum + cin
    assign s  = s1 ^ cin;
    assign c2 = s1 & cin;

    assign cout = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial add/subtract controller. A single full-adder cell is stepped
// LSB-first across WIDTH bits, one bit per clock, with the carry held in a
// flop between bits. Subtraction is A + ~B + 1 (B inverted at load, carry
// seeded with 1).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, op_sub)
//   out_valid / out_ready: result handshake (sum, cout, ovf)
//   sum                  : WIDTH-bit wrapped result
//   cout                 : final carry (subtract: 1 = no borrow)
//   ovf                  : signed overflow
//   busy                 : operation in flight (RUN or DONE)
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cmsb_q;   // carry into the MSB position
    logic               cout_q;
    logic               ovf_q;

    logic               fa_s;
    logic               fa_c;

    bit_full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_c)
    );

    // Handshake outputs decode registered state only; in_ready is also
    // gated by rst so nothing is accepted while reset is held.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cmsb_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= op_sub ? ~b : b;
                        carry_q <= op_sub;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + 1'b1;
                    // carry out of bit WIDTH-2 is the carry into the MSB
                    if (cnt_q == CNT_W'(WIDTH - 2)) begin
                        cmsb_q <= fa_c;
                    end
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        cout_q  <= fa_c;
                        ovf_q   <= cmsb_q ^ fa_c;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Directed self-checking bench for serial_add_ctrl with WIDTH = 8.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    int n_vec;
    int n_bad;

    // accept monitor
    int cyc_n;
    int acc_cnt;
    int acc_cyc [0:63];

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (in_valid && in_ready) begin
            acc_cyc[acc_cnt % 64] = cyc_n;
            acc_cnt = acc_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete transaction with latency and handshake checks.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic ts, input logic [7:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; op_sub = ts; in_valid = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = WIDTH + 7;
        for (int k = 1; k <= WIDTH + 6; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, ".latency"}, 32'(lat), 32'(WIDTH + 1));
        chk({tag, ".sum"}, 32'(sum), 32'(es));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".idle_ov"}, 32'(out_valid), 32'd0);
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ".idle_rdy"}, 32'(in_ready), 32'd1);
    endtask

    // back-to-back vectors: a, b, op_sub, sum, cout, ovf
    logic [7:0] bb_a   [0:2] = '{8'h3C, 8'hC8, 8'hAA};
    logic [7:0] bb_b   [0:2] = '{8'h5A, 8'h64, 8'h55};
    logic       bb_s   [0:2] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] bb_sum [0:2] = '{8'h96, 8'h64, 8'hFF};
    logic       bb_co  [0:2] = '{1'b0, 1'b1, 1'b0};
    logic       bb_ov  [0:2] = '{1'b1, 1'b1, 1'b0};

    initial begin
        int base;
        int lat;
        int seen_ov;
        int idx_in;
        int r;
        logic [7:0] held;

        n_vec = 0; n_bad = 0; cyc_n = 0; acc_cnt = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.sum", 32'(sum), 32'd0);
        chk("rst.cout", 32'(cout), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1 chk("rst.in_ready_rel", 32'(in_ready), 32'd1);

        // add and boundary cases
        run_op("add",     8'h25, 8'h1A, 1'b0, 8'h3F, 1'b0, 1'b0);
        run_op("wrap",    8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sovf",    8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub",     8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("sub_ovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // backpressure, with a second request held valid throughout
        base = acc_cnt;
        @(negedge clk);
        a = 8'h25; b = 8'h1A; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 a = 8'h10; b = 8'h20; op_sub = 1'b1;
        lat = 0;
        for (int k = 0; k < WIDTH + 6; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = 1;
                break;
            end
        end
        chk("bp.done_seen", 32'(lat), 32'd1);
        held = sum;
        chk("bp.sum", 32'(held), 32'h3F);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp.out_valid_hold", 32'(out_valid), 32'd1);
            chk("bp.sum_hold", 32'(sum), 32'(held));
            chk("bp.in_ready_hold", 32'(in_ready), 32'd0);
        end
        chk("bp.accepts_held", 32'(acc_cnt - base), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp.idle_rdy", 32'(in_ready), 32'd1);
        chk("bp.idle_ov", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp.accepts_after", 32'(acc_cnt - base), 32'd2);
        lat = 0;
        for (int k = 0; k < WIDTH + 6; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = 1;
                break;
            end
        end
        chk("bp.second_seen", 32'(lat), 32'd1);
        chk("bp.second_sum", 32'(sum), 32'hF0);
        chk("bp.second_cout", 32'(cout), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp.accepts_final", 32'(acc_cnt - base), 32'd2);

        // reset during RUN
        @(negedge clk);
        a = 8'h25; b = 8'h1A; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid.sum", 32'(sum), 32'd0);
        chk("mid.cout", 32'(cout), 32'd0);
        chk("mid.ovf", 32'(ovf), 32'd0);
        chk("mid.out_valid", 32'(out_valid), 32'd0);
        chk("mid.busy", 32'(busy), 32'd0);
        chk("mid.in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        seen_ov = 0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(negedge clk);
            if (out_valid) seen_ov++;
        end
        chk("mid.no_out_valid", 32'(seen_ov), 32'd0);
        chk("mid.in_ready_after", 32'(in_ready), 32'd1);
        run_op("mid.new", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // back-to-back with out_ready tied high
        base = acc_cnt;
        idx_in = 0;
        r = 0;
        @(negedge clk);
        a = bb_a[0]; b = bb_b[0]; op_sub = bb_s[0];
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && r < 3; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                chk("b2b.sum", 32'(sum), 32'(bb_sum[r]));
                chk("b2b.cout", 32'(cout), 32'(bb_co[r]));
                chk("b2b.ovf", 32'(ovf), 32'(bb_ov[r]));
                r++;
            end
            if (acc_cnt - base > idx_in) begin
                idx_in++;
                if (idx_in < 3) begin
                    a = bb_a[idx_in]; b = bb_b[idx_in]; op_sub = bb_s[idx_in];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b.results", 32'(r), 32'd3);
        chk("b2b.accepts", 32'(acc_cnt - base), 32'd3);
        chk("b2b.gap1", 32'(acc_cyc[(base + 1) % 64] - acc_cyc[base % 64]), 32'(WIDTH + 2));
        chk("b2b.gap2", 32'(acc_cyc[(base + 2) % 64] - acc_cyc[(base + 1) % 64]), 32'(WIDTH + 2));

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
